// File: rtl/brisc_pkg.sv
// Shared types for the brisc pipeline hazard controller: miss-wait states,
// forward-select encoding and the select-width helper.
package brisc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    I_WAIT  = 2'd1,
    D_WAIT  = 2'd2,
    ID_WAIT = 2'd3
  } hz_state_e;

  localparam int unsigned FWD_DEPTH_MAX = 3;

  // Forward source: register file, or post-EX stage k-1 encoded as k.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_C  = 2'd1,
    FWD_WB = 2'd2,
    FWD_S3 = 2'd3
  } fwd_src_e;

  function automatic int unsigned fwd_sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority encoder choosing the nearest post-EX stage that writes a given
// source register; x0 always reads the register file.
module fwd_sel import brisc_pkg::*; #(
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned SEL_W     = fwd_sel_w(FWD_DEPTH)
) (
  input  logic [REG_BITS-1:0]           rs,
  input  logic [FWD_DEPTH*REG_BITS-1:0] rd_fwd,
  input  logic [FWD_DEPTH-1:0]          reg_write_fwd,
  output logic [SEL_W-1:0]              sel
);

  fwd_src_e src;

  // Walk from the farthest stage inward so the nearest match wins.
  always_comb begin
    src = FWD_RF;
    if (rs != '0) begin
      for (int unsigned k = FWD_DEPTH; k > 0; k--) begin
        if (reg_write_fwd[k-1] && (rd_fwd[(k-1)*REG_BITS +: REG_BITS] == rs))
          src = fwd_src_e'(2'(k));
      end
    end
  end

  assign sel = SEL_W'(src);

endmodule

// File: rtl/hazard_ctrl.sv
// Stateful hazard controller: forwarding, load-use, redirect and cache-miss
// freezes. Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl import brisc_pkg::*; #(
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REG_BITS-1:0]              rs1_D_in,
  input  logic [REG_BITS-1:0]              rs2_D_in,
  input  logic [REG_BITS-1:0]              rs1_EX_in,
  input  logic [REG_BITS-1:0]              rs2_EX_in,
  input  logic [REG_BITS-1:0]              rd_EX_in,
  input  logic                             load_EX_in,
  input  logic [FWD_DEPTH*REG_BITS-1:0]    rd_fwd_in,
  input  logic [FWD_DEPTH-1:0]             reg_write_fwd_in,
  input  logic                             pc_src_in,
  input  logic                             imiss_in,
  input  logic                             ifill_done_in,
  input  logic                             dmiss_in,
  input  logic                             dfill_done_in,
  output logic [fwd_sel_w(FWD_DEPTH)-1:0]  fwd_src1_out,
  output logic [fwd_sel_w(FWD_DEPTH)-1:0]  fwd_src2_out,
  output logic                             stall_F_out,
  output logic                             stall_D_out,
  output logic                             stall_EX_out,
  output logic                             stall_C_out,
  output logic                             flush_D_out,
  output logic                             flush_EX_out,
  output logic                             flush_WB_out,
  output logic [CNT_W-1:0]                 stall_cycles_out,
  output logic [CNT_W-1:0]                 flush_events_out
);

  localparam int unsigned FWD_SEL_W = fwd_sel_w(FWD_DEPTH);

  fwd_sel #(
    .REG_BITS (REG_BITS),
    .FWD_DEPTH(FWD_DEPTH),
    .SEL_W    (FWD_SEL_W)
  ) u_fwd_sel1 (
    .rs           (rs1_EX_in),
    .rd_fwd       (rd_fwd_in),
    .reg_write_fwd(reg_write_fwd_in),
    .sel          (fwd_src1_out)
  );

  fwd_sel #(
    .REG_BITS (REG_BITS),
    .FWD_DEPTH(FWD_DEPTH),
    .SEL_W    (FWD_SEL_W)
  ) u_fwd_sel2 (
    .rs           (rs2_EX_in),
    .rd_fwd       (rd_fwd_in),
    .reg_write_fwd(reg_write_fwd_in),
    .sel          (fwd_src2_out)
  );

  hz_state_e state, state_nxt;
  logic      discard, discard_nxt;
  logic      i_pend, d_pend, i_act, d_act, i_end;
  logic      redirect, load_use, discard_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  // A wait is live while its miss is raised or it is pending and its fill has
  // not arrived; the same terms give the pending bits for the next cycle.
  always_comb begin
    i_pend        = (state == I_WAIT) || (state == ID_WAIT);
    d_pend        = (state == D_WAIT) || (state == ID_WAIT);
    i_act         = imiss_in || (i_pend && !ifill_done_in);
    d_act         = dmiss_in || (d_pend && !dfill_done_in);
    i_end         = i_pend && ifill_done_in;
    redirect      = pc_src_in && !d_act;
    load_use      = load_EX_in && (rd_EX_in != '0) &&
                    ((rd_EX_in == rs1_D_in) || (rd_EX_in == rs2_D_in));
    discard_flush = i_end && discard;
    discard_nxt   = (discard && !i_end) || (redirect && i_act);

    case ({i_act, d_act})
      2'b10:   state_nxt = I_WAIT;
      2'b01:   state_nxt = D_WAIT;
      2'b11:   state_nxt = ID_WAIT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_F_out  = 1'b0;
    stall_D_out  = 1'b0;
    stall_EX_out = 1'b0;
    stall_C_out  = 1'b0;
    flush_D_out  = 1'b0;
    flush_EX_out = 1'b0;
    flush_WB_out = 1'b0;
    if (d_act) begin
      stall_F_out  = 1'b1;
      stall_D_out  = 1'b1;
      stall_EX_out = 1'b1;
      stall_C_out  = 1'b1;
      flush_WB_out = 1'b1;
    end else begin
      // Redirect lets F load the new PC even during an I wait.
      stall_F_out  = !redirect && (load_use || i_act);
      stall_D_out  = !redirect && load_use;
      flush_EX_out = redirect || load_use;
      flush_D_out  = redirect || (!load_use && (i_act || discard_flush));
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_any, flush_any;

  assign stall_any = stall_F_out || stall_D_out || stall_EX_out || stall_C_out;
  assign flush_any = flush_D_out || flush_EX_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_any && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_any && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles_out = stall_cnt;
  assign flush_events_out = flush_cnt;
`else
  assign stall_cycles_out = '0;
  assign flush_events_out = '0;
`endif

endmodule
